led_scan_ctrl: RTL and testbench
================================

// Module: led_scan_ctrl
// PURPOSE
//   Parametrised column-scan engine for the LED matrix driver. It holds a double-buffered
//   frame, steps through the columns one at a time, and drives a one-hot column select with
//   that column's row data. Each column is shown for a programmable dwell time, followed by
//   an optional blanking gap that suppresses ghosting. It sits between the frame-load logic
//   and the matrix pin drivers.
// PARAMETERS
//   ROWS          8   rows per column (width of row_out)
//   COLS          8   columns scanned (width of col_out); must be >= 2
//   DWELL_W       8   width of the dwell input
//   BLANK_CYCLES  2   all-off cycles between columns; 0 removes the BLANK state
// PORTS
//   clk          in   1             system clock
//   rst          in   1             synchronous reset, active-high
//   en           in   1             scan enable
//   dwell        in   DWELL_W       DRIVE length in cycles (0 is treated as 1); sampled on DRIVE entry
//   fb_in        in   ROWS*COLS     new frame; column c is fb_in[c*ROWS +: ROWS]
//   fb_load      in   1             1-cycle strobe: capture fb_in into the pending buffer
//   pend_full    out  1             pending frame is waiting for a swap
//   col_out      out  COLS          one-hot column select; all zero when not driving
//   row_out      out  ROWS          row data for the driven column; zero when not driving
//   col_idx      out  clog2(COLS)   current column index
//   frame_start  out  1             1-cycle pulse on the first DRIVE cycle of column 0
// BEHAVIOUR
//   - Every output is registered. On reset, all outputs are 0, the state is IDLE, and both
//     buffers are 0.
//   - States: IDLE -> BLANK -> DRIVE -> BLANK -> ...
//       IDLE : outputs 0, col_idx=0. On en=1, go to BLANK, or straight to DRIVE if
//              BLANK_CYCLES=0.
//       BLANK: col_out=0, row_out=0 for exactly BLANK_CYCLES cycles, then go to DRIVE.
//       DRIVE: col_out=1<<col_idx, row_out=active[col_idx*ROWS +: ROWS] for max(dwell,1)
//              cycles. On exit, col_idx increments, wrapping from COLS-1 to 0.
//   - Column period = max(dwell,1) + BLANK_CYCLES cycles.
//     Frame period = COLS times the column period.
//   - en=0 in any state: go to IDLE on the next edge, outputs 0, col_idx=0. The active
//     buffer and the pending buffer are both kept.
//   - Buffering:
//       fb_load=1 : pending<=fb_in and pend_full<=1. A later load overwrites an unswapped
//                   one (latest wins).
//       Swap      : on the last DRIVE cycle of column COLS-1 with pend_full=1,
//                   active<=pending and pend_full<=0. A swap never happens mid-frame.
//       fb_load on the swap cycle: the old pending moves to active, fb_in becomes the new
//                   pending, and pend_full stays 1.
//   - Changing dwell mid-column has no effect until the next DRIVE entry.
//   - rst mid-scan overrides everything, including a same-cycle fb_load.
// CONFIGURATION
//   LED_DIM_EN defined:
//     - Adds input dim [DWELL_W-1:0].
//     - During DRIVE, row_out is forced to 0 once the in-column cycle count is >= dim.
//       col_out is not affected.
//     - dim >= dwell gives full brightness; dim = 0 gives dark rows.
//     - dim is sampled on DRIVE entry.
//   LED_DIM_EN undefined:
//     - No dim port; row_out is valid for the whole DRIVE.
// TESTING
//   1. Reset, fb_load frame with column c = 8'h11*c, en=1, dwell=3 ->
//      col_out walks 01,02,..,80. Each column gives 3 DRIVE cycles with row_out=11*c,
//      then 2 zero cycles. frame_start fires once every 40 cycles.
//   2. dwell=0 -> each DRIVE lasts 1 cycle; the period is 3 cycles per column.
//   3. fb_load a second frame mid-frame -> pend_full=1. The old data finishes to column 7;
//      the new data appears at the next column 0 and pend_full drops.
//   4. fb_load exactly on the swap cycle -> active takes the previous pending;
//      pend_full stays 1 and swaps again at the next frame end.
//   5. en=0 during DRIVE of column 5 -> outputs 0 and col_idx=0 the next cycle.
//      Re-enabling restarts from column 0 with a BLANK first. Repeat with rst=1 mid-DRIVE
//      and check all outputs and buffers are 0.
//   6. (LED_DIM_EN) dwell=8, dim=3 -> row_out is non-zero for 3 of the 8 DRIVE cycles,
//      and col_out stays high for all 8.

Source files
------------

// File: rtl/led_scan_ctrl_if.sv
// Bus between the frame-load logic (master) and the LED column-scan engine (slave).
// LED_DIM_EN adds the dim input.
interface led_scan_ctrl_if #(
    parameter int unsigned ROWS    = 8,
    parameter int unsigned COLS    = 8,
    parameter int unsigned DWELL_W = 8
);
    localparam int unsigned IDX_W = $clog2(COLS);

    logic                 en;
    logic [DWELL_W-1:0]   dwell;
    logic [ROWS*COLS-1:0] fb_in;
    logic                 fb_load;
    logic                 pend_full;
    logic [COLS-1:0]      col_out;
    logic [ROWS-1:0]      row_out;
    logic [IDX_W-1:0]     col_idx;
    logic                 frame_start;
`ifdef LED_DIM_EN
    logic [DWELL_W-1:0]   dim;

    modport master (
        output en, dwell, fb_in, fb_load, dim,
        input  pend_full, col_out, row_out, col_idx, frame_start
    );
    modport slave (
        input  en, dwell, fb_in, fb_load, dim,
        output pend_full, col_out, row_out, col_idx, frame_start
    );
`else
    modport master (
        output en, dwell, fb_in, fb_load,
        input  pend_full, col_out, row_out, col_idx, frame_start
    );
    modport slave (
        input  en, dwell, fb_in, fb_load,
        output pend_full, col_out, row_out, col_idx, frame_start
    );
`endif
endinterface

// File: rtl/led_scan_ctrl.sv
// Double-buffered LED matrix column-scan engine with dwell time and blanking gap.
// Define LED_DIM_EN to add per-column dimming via the dim input.
module led_scan_ctrl #(
    parameter int unsigned ROWS         = 8,
    parameter int unsigned COLS         = 8,
    parameter int unsigned DWELL_W      = 8,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input logic            clk,
    input logic            rst,
    led_scan_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(COLS);
    localparam int unsigned BLK_W = $clog2(BLANK_CYCLES + 1);
    localparam int unsigned CNT_W = (DWELL_W > BLK_W) ? DWELL_W : BLK_W;

    typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     len_q, len_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [ROWS*COLS-1:0] active_q, active_d;
    logic [ROWS*COLS-1:0] pending_q, pending_d;
    logic                 pend_q, pend_d;
    logic [COLS-1:0]      col_q, col_d;
    logic [ROWS-1:0]      row_q, row_d;
    logic                 start_q, start_d;
    logic                 drive_last, drive_entry, swap;
`ifdef LED_DIM_EN
    logic [CNT_W-1:0]     dim_q, dim_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            active_q  <= '0;
            pending_q <= '0;
            pend_q    <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            start_q   <= 1'b0;
`ifdef LED_DIM_EN
            dim_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            pend_q    <= pend_d;
            col_q     <= col_d;
            row_q     <= row_d;
            start_q   <= start_d;
`ifdef LED_DIM_EN
            dim_q     <= dim_d;
`endif
        end
    end

    // cnt_q counts cycles within the current BLANK or DRIVE stretch
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        idx_d       = idx_q;
        drive_entry = 1'b0;
        drive_last  = (state_q == StDrive) && (cnt_q == len_q - 1'b1);
        if (!bus.en) begin
            state_d = StIdle;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (BLANK_CYCLES == 0) begin
                        state_d     = StDrive;
                        drive_entry = 1'b1;
                    end else begin
                        state_d = StBlank;
                    end
                end
                StBlank: begin
                    if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                        state_d     = StDrive;
                        cnt_d       = '0;
                        drive_entry = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StDrive: begin
                    if (drive_last) begin
                        cnt_d = '0;
                        idx_d = (idx_q == IDX_W'(COLS - 1)) ? '0 : idx_q + 1'b1;
                        if (BLANK_CYCLES == 0) begin
                            drive_entry = 1'b1;
                        end else begin
                            state_d = StBlank;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        if (drive_entry) begin
            len_d = (bus.dwell == '0) ? CNT_W'(1) : CNT_W'(bus.dwell);
        end
    end

    // Swap only at the end of a completed frame; a same-cycle load becomes the new pending
    always_comb begin
        swap      = bus.en && drive_last && (idx_q == IDX_W'(COLS - 1)) && pend_q;
        active_d  = swap ? pending_q : active_q;
        pending_d = bus.fb_load ? bus.fb_in : pending_q;
        pend_d    = bus.fb_load | (pend_q & ~swap);
`ifdef LED_DIM_EN
        dim_d     = drive_entry ? CNT_W'(bus.dim) : dim_q;
`endif
    end

    always_comb begin
        col_d   = '0;
        row_d   = '0;
        start_d = 1'b0;
        if (state_d == StDrive) begin
            col_d   = COLS'(1) << idx_d;
            row_d   = active_d[idx_d*ROWS +: ROWS];
            start_d = drive_entry && (idx_d == '0);
`ifdef LED_DIM_EN
            if (cnt_d >= dim_d) begin
                row_d = '0;
            end
`endif
        end
    end

    assign bus.pend_full   = pend_q;
    assign bus.col_out     = col_q;
    assign bus.row_out     = row_q;
    assign bus.col_idx     = idx_q;
    assign bus.frame_start = start_q;
endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl: directed scenarios plus random traffic against a
// time-position reference model. Define LED_DIM_EN to also exercise dimming.
module tb_led_scan_ctrl;
    localparam int unsigned ROWS         = 8;
    localparam int unsigned COLS         = 8;
    localparam int unsigned DWELL_W      = 8;
    localparam int unsigned BLANK_CYCLES = 2;
    localparam int unsigned FBW          = ROWS * COLS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_scan_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .DWELL_W(DWELL_W)) bus ();

    led_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .DWELL_W(DWELL_W), .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int fails  = 0;

    // Model: position m_t counts cycles since the scan started; everything else follows
    bit             m_run = 0;
    int             m_t = 0;
    int             m_len = 1;
    int             m_dim = 0;
    logic [FBW-1:0] m_active = '0;
    logic [FBW-1:0] m_pending = '0;
    bit             m_pfull = 0;

    function automatic int period();
        return m_len + int'(BLANK_CYCLES);
    endfunction
    function automatic int cur_col();
        return (m_t / period()) % int'(COLS);
    endfunction
    function automatic int cur_off();
        return m_t % period();
    endfunction
    function automatic bit driving();
        return m_run && (cur_off() >= int'(BLANK_CYCLES));
    endfunction
    function automatic bit swap_next();
        return m_run && bus.en && m_pfull && (cur_off() == period() - 1) &&
               (cur_col() == int'(COLS) - 1);
    endfunction
    function automatic logic [FBW-1:0] rand_frame();
        return FBW'({$urandom(), $urandom()});
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_run = 0; m_t = 0; m_active = '0; m_pending = '0; m_pfull = 0;
            return;
        end
        if (swap_next()) begin
            m_active = m_pending;
            m_pfull  = 0;
        end
        if (bus.fb_load) begin
            m_pending = bus.fb_in;
            m_pfull   = 1;
        end
        if (!bus.en) begin
            m_run = 0;
        end else if (!m_run) begin
            m_run = 1;
            m_t   = 0;
            m_len = (bus.dwell == '0) ? 1 : int'(bus.dwell);
`ifdef LED_DIM_EN
            m_dim = int'(bus.dim);
`endif
        end else begin
            m_t++;
        end
    endtask

    task automatic check_cycle();
        logic [COLS-1:0] e_col;
        logic [ROWS-1:0] e_row;
        logic            e_fs;
        int              e_idx;
        int              k;
        e_col = '0; e_row = '0; e_fs = 1'b0; e_idx = 0;
        if (m_run) begin
            e_idx = cur_col();
            if (driving()) begin
                k     = cur_off() - int'(BLANK_CYCLES);
                e_col = COLS'(1) << e_idx;
                e_row = m_active[e_idx*ROWS +: ROWS];
                e_fs  = (k == 0) && (e_idx == 0);
`ifdef LED_DIM_EN
                if (k >= m_dim) e_row = '0;
`endif
            end
        end
        chk("col_out", 64'(bus.col_out), 64'(e_col));
        chk("row_out", 64'(bus.row_out), 64'(e_row));
        chk("col_idx", 64'(bus.col_idx), 64'(e_idx));
        chk("frame_start", 64'(bus.frame_start), 64'(e_fs));
        chk("pend_full", 64'(bus.pend_full), 64'(m_pfull));
    endtask

    task automatic cycle(input bit load, input logic [FBW-1:0] frame);
        bus.fb_load = load;
        bus.fb_in   = frame;
        model_edge();
        @(posedge clk);
        #1;
        bus.fb_load = 1'b0;
        check_cycle();
    endtask

    task automatic run_to_drive(input int col);
        int n;
        n = 0;
        while (!(driving() && cur_col() == col) && n < 400) begin
            cycle(1'b0, '0);
            n++;
        end
        chk("reach_drive_col", 64'(driving() && cur_col() == col), 64'(1));
    endtask

    logic [FBW-1:0] f1, f2, f3, f4;
    int fs_cnt, n, ncol, nrow;

    initial begin
        bus.en = 1'b0; bus.dwell = '0; bus.fb_in = '0; bus.fb_load = 1'b0;
`ifdef LED_DIM_EN
        bus.dim = '1;
`endif
        // Reset state
        repeat (2) cycle(1'b0, '0);
        rst = 1'b0;

        // 1: column c = 8'h11*c, dwell=3, two frames
        for (int c = 0; c < int'(COLS); c++) f1[c*ROWS +: ROWS] = ROWS'(8'h11 * c);
        cycle(1'b1, f1);
        bus.dwell = DWELL_W'(3);
        bus.en = 1'b1;
        cycle(1'b0, '0);
        run_to_drive(0);
        run_to_drive(int'(COLS) - 1);
        bus.en = 1'b0;
        cycle(1'b0, '0);
        bus.en = 1'b1;
        fs_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            cycle(1'b0, '0);
            if (bus.frame_start) fs_cnt++;
        end
        chk("frame_start_per_80", 64'(fs_cnt), 64'(2));

        // 2: dwell=0 acts as 1, 3 cycles per column
        bus.en = 1'b0;
        bus.dwell = '0;
        cycle(1'b0, '0);
        bus.en = 1'b1;
        repeat (48) cycle(1'b0, '0);

        // 3: mid-frame load waits for the frame end
        f2 = rand_frame();
        run_to_drive(3);
        cycle(1'b1, f2);
        chk("pend_after_load", 64'(bus.pend_full), 64'(1));
        run_to_drive(0);
        chk("pend_after_swap", 64'(bus.pend_full), 64'(0));
        chk("new_frame_col0", 64'(bus.row_out), 64'(f2[0 +: ROWS]));

        // 4: load on the swap cycle
        f3 = rand_frame();
        f4 = rand_frame();
        cycle(1'b1, f3);
        n = 0;
        while (!swap_next() && n < 200) begin
            cycle(1'b0, '0);
            n++;
        end
        chk("found_swap_cycle", 64'(swap_next()), 64'(1));
        cycle(1'b1, f4);
        chk("pend_kept_on_swap", 64'(bus.pend_full), 64'(1));
        repeat (2 * 3 * COLS) cycle(1'b0, '0);
        chk("pend_second_swap", 64'(bus.pend_full), 64'(0));

        // 5: en=0 during DRIVE of column 5, then rst mid-DRIVE with a same-cycle load
        bus.dwell = DWELL_W'(2);
        bus.en = 1'b0;
        cycle(1'b0, '0);
        bus.en = 1'b1;
        run_to_drive(5);
        bus.en = 1'b0;
        cycle(1'b0, '0);
        chk("disable_col_out", 64'(bus.col_out), 64'(0));
        chk("disable_col_idx", 64'(bus.col_idx), 64'(0));
        bus.en = 1'b1;
        cycle(1'b0, '0);
        chk("restart_blank", 64'(bus.col_out), 64'(0));
        cycle(1'b1, rand_frame());
        run_to_drive(5);
        rst = 1'b1;
        cycle(1'b1, rand_frame());
        rst = 1'b0;
        chk("rst_pend", 64'(bus.pend_full), 64'(0));
        nrow = 0;
        repeat (2 * 4 * COLS) begin
            cycle(1'b0, '0);
            if (bus.row_out != '0) nrow++;
        end
        chk("rst_active_zero", 64'(nrow), 64'(0));

`ifdef LED_DIM_EN
        // 6: dwell=8, dim=3
        bus.en = 1'b0;
        cycle(1'b0, '0);
        bus.dwell = DWELL_W'(8);
        bus.dim = DWELL_W'(3);
        bus.en = 1'b1;
        cycle(1'b1, '1);
        repeat (80) cycle(1'b0, '0);
        ncol = 0;
        nrow = 0;
        repeat (12) begin
            cycle(1'b0, '0);
            if (bus.col_out == COLS'(1)) begin
                ncol++;
                if (bus.row_out != '0) nrow++;
            end
        end
        chk("dim_col_cycles", 64'(ncol), 64'(8));
        chk("dim_row_cycles", 64'(nrow), 64'(3));
`endif

        // Random traffic; dwell/dim only change while the scan is disabled
        bus.en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(39) == 0) bus.en = ~bus.en;
            if (!bus.en) begin
                bus.dwell = DWELL_W'($urandom_range(4));
`ifdef LED_DIM_EN
                bus.dim = DWELL_W'($urandom_range(5));
`endif
            end
            rst = ($urandom_range(299) == 0);
            if ($urandom_range(24) == 0) cycle(1'b1, rand_frame());
            else cycle(1'b0, '0);
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
